// File: rtl/spi_sample_rx.sv
// SPI slave receiver for sign-magnitude audio sample frames; delivers each sample to the clk
// domain through a one-entry valid/ready holding register with overrun and frame-error flags.
module spi_sample_rx #(
  parameter int unsigned DATA_BITS   = 11,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 sdi,
  input  logic                 ncs,
  input  logic                 ready,
  input  logic                 clear,
  output logic                 valid,
  output logic [DATA_BITS-1:0] sample,
  output logic [DATA_BITS-1:0] sampleTc,
  output logic                 frameErr,
  output logic                 overrun
);

  localparam int unsigned CntW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DATA_BITS);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync, sdi_sync, ncs_sync, live_sync;
  logic                   sclk_prev, ncs_prev, armed;
  logic                   sclk_s, sdi_s, ncs_s;
  logic                   sclk_rise, ncs_rise, ncs_fall;

  state_e                 state;
  logic [CntW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   mag_ext, tc_next;
  logic                   deliver;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync[SYNC_STAGES-1];

  // The ncs reset value of 1 is not a real high: a falling edge only counts once a genuine
  // pin-derived high has been seen, so a frame in flight across reset release is skipped.
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign ncs_rise  = ncs_s & ~ncs_prev;
  assign ncs_fall  = ~ncs_s & ncs_prev & armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      sdi_sync  <= '0;
      ncs_sync  <= '1;
      live_sync <= '0;
      sclk_prev <= 1'b0;
      ncs_prev  <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      live_sync <= {live_sync[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sclk_s;
      ncs_prev  <= ncs_s;
      armed     <= armed | (live_sync[SYNC_STAGES-1] & ncs_s);
    end
  end

  always_comb begin
    mag_ext = {1'b0, shreg[DATA_BITS-2:0]};
    tc_next = shreg[DATA_BITS-1] ? (~mag_ext + DATA_BITS'(1)) : mag_ext;
    deliver = (state == StDone) && (bit_cnt == CntFull);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      bit_cnt  <= '0;
      shreg    <= '0;
      valid    <= 1'b0;
      sample   <= '0;
      sampleTc <= '0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      frameErr <= 1'b0;
      case (state)
        StIdle: begin
          if (ncs_fall) begin
            bit_cnt <= '0;
            state   <= StShift;
          end
        end
        StShift: begin
          if (sclk_rise && (bit_cnt < CntFull)) begin
            shreg   <= {shreg[DATA_BITS-2:0], sdi_s};
            bit_cnt <= bit_cnt + CntW'(1);
          end
          if (ncs_rise) state <= StDone;
        end
        StDone: begin
          if (bit_cnt != CntFull) frameErr <= 1'b1;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase

      if (deliver && (!valid || ready)) begin
        sample   <= shreg;
        sampleTc <= tc_next;
        valid    <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      // A fresh overrun wins over a simultaneous clear.
      overrun <= (overrun & ~clear) | (deliver & valid & ~ready);
    end
  end

endmodule
